// File: rtl/sample_pkg.sv
// Shared constants and FSM encoding for the sample pacer and its FIFO.
package sample_pkg;

  localparam int unsigned DEF_DW    = 16;
  localparam int unsigned DEF_DEPTH = 8;
  localparam int unsigned DEF_PRIME = 4;
  localparam int unsigned CNT_W     = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PRIME = 2'b01,
    ST_RUN   = 2'b10
  } state_e;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO with no fall-through; pointers carry an extra MSB so
// full and empty are distinguished by the pointer difference.
module sample_fifo
  import sample_pkg::*;
#(
  parameter int unsigned DW    = DEF_DW,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DW-1:0]            din,
  output logic [DW-1:0]            head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic          w_push;
  logic          w_pop;

  assign level  = r_wr_ptr - r_rd_ptr;
  assign full   = (level == LW'(DEPTH));
  assign empty  = (level == '0);
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign head   = r_mem[r_rd_ptr[AW-1:0]];

  // Flush wins over both push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + LW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !flush) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/sample_pacer.sv
// Buffers upstream samples and releases one every `period` cycles once the
// FIFO has primed; flags underrun when a tick finds the FIFO empty.
module sample_pacer
  import sample_pkg::*;
#(
  parameter int unsigned DW    = DEF_DW,
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned PRIME = DEF_PRIME
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     flush,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic signed [DW-1:0]     s_data,
  input  logic [CNT_W-1:0]         period,
  output logic signed [DW-1:0]     dout,
  output logic                     data_refresh,
  output logic                     underrun,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_period_m1;
  logic              w_tick;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [DW-1:0]     w_head;

  sample_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (s_valid),
    .pop   (w_pop),
    .din   (s_data),
    .head  (w_head),
    .level (level),
    .full  (w_full),
    .empty (w_empty)
  );

  assign s_ready     = !w_full;
  assign w_period_m1 = (period == '0) ? '0 : period - CNT_W'(1);
  assign w_pop       = w_tick && !w_empty;

  // Next state and tick; >= lets a shortened period fire immediately.
  always_comb begin
    w_state_nxt = r_state;
    w_tick      = 1'b0;
    if (!enable || flush) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  w_state_nxt = ST_PRIME;
        ST_PRIME: if (level >= LW'(PRIME)) w_state_nxt = ST_RUN;
        ST_RUN: begin
          w_state_nxt = ST_RUN;
          w_tick      = (r_cnt >= w_period_m1);
        end
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      dout         <= '0;
      data_refresh <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      data_refresh <= w_pop;
      underrun     <= w_tick && w_empty;
      if (w_pop) dout <= w_head;
      // Counter restarts on RUN entry, on every tick, and on flush/disable.
      if ((r_state != ST_RUN) || !enable || flush || w_tick) r_cnt <= '0;
      else r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_sample_pacer.sv
// Directed bench for sample_pacer with a sample scoreboard on data_refresh.
module tb_sample_pacer;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               enable = 1'b0;
  logic               flush = 1'b0;
  logic               s_valid = 1'b0;
  logic signed [15:0] s_data = '0;
  logic [15:0]        period = 16'd1;

  logic               a_s_ready, b_s_ready;
  logic signed [15:0] a_dout, b_dout;
  logic               a_refresh, b_refresh;
  logic               a_underrun, b_underrun;
  logic [3:0]         a_level, b_level;

  int                 checks = 0;
  int                 failures = 0;
  int                 n_ref = 0;
  int                 n;
  int                 ref0;
  logic signed [15:0] sb_q[$];

  always #5 clk = ~clk;

  sample_pacer u_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .flush(flush),
    .s_valid(s_valid), .s_ready(a_s_ready), .s_data(s_data), .period(period),
    .dout(a_dout), .data_refresh(a_refresh), .underrun(a_underrun), .level(a_level)
  );

  sample_pacer #(.PRIME(2)) u_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .flush(flush),
    .s_valid(s_valid), .s_ready(b_s_ready), .s_data(s_data), .period(period),
    .dout(b_dout), .data_refresh(b_refresh), .underrun(b_underrun), .level(b_level)
  );

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock; outputs sampled 1ns after the edge, refreshes scored on u_a.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (a_refresh === 1'b1) begin
      n_ref++;
      if (sb_q.size() == 0) check("unexpected_refresh", 1, 0);
      else check("dout_order", a_dout, sb_q.pop_front());
    end
  endtask

  task automatic push(input logic signed [15:0] v);
    s_valid = 1'b1;
    s_data  = v;
    if (a_s_ready === 1'b1) sb_q.push_back(v);
    cyc();
    s_valid = 1'b0;
  endtask

  task automatic do_flush();
    enable = 1'b0;
    flush  = 1'b1;
    cyc();
    flush  = 1'b0;
    sb_q.delete();
  endtask

  task automatic wait_ref(input int max_c, output int waited);
    waited = 0;
    do begin
      cyc();
      waited++;
    end while (a_refresh !== 1'b1 && waited < max_c);
    if (a_refresh !== 1'b1) check("refresh_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    // Reset values
    #12;
    check("rst_level", a_level, 0);
    check("rst_ready", a_s_ready, 1);
    check("rst_dout", a_dout, 0);
    check("rst_refresh", a_refresh, 0);
    check("rst_underrun", a_underrun, 0);
    check("rst_ready_b", b_s_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // Basic pacing at period 3
    period = 16'd3;
    push(100); push(-200); push(300); push(-400);
    check("t1_level", a_level, 4);
    enable = 1'b1;
    wait_ref(10, n);
    check("t1_first_latency", n, 5);
    for (int i = 0; i < 3; i++) begin
      wait_ref(10, n);
      check("t1_spacing", n, 3);
    end
    for (int k = 1; k <= 3; k++) begin
      cyc();
      check("t1_underrun", a_underrun, k == 3);
    end
    check("t1_dout_held", a_dout, -400);

    // Underrun with PRIME=2 instance
    do_flush();
    period = 16'd2;
    push(11); push(-22);
    check("t2_level_b", b_level, 2);
    enable = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      check("t2_refresh_b", b_refresh, (k == 4) || (k == 6));
      check("t2_underrun_b", b_underrun, (k >= 8) && (k % 2 == 0));
      if (k >= 4) check("t2_dout_b", b_dout, (k < 6) ? 11 : -22);
    end

    // Fill to full with pacing disabled
    do_flush();
    ref0 = n_ref;
    for (int i = 0; i < 9; i++) begin
      check("t3_ready", a_s_ready, i < 8);
      push(16'(i + 1));
    end
    check("t3_level", a_level, 8);
    check("t3_ready_full", a_s_ready, 0);
    check("t3_no_refresh", n_ref - ref0, 0);

    // Period 0 then period 1: every-cycle pacing
    for (int p = 0; p < 2; p++) begin
      if (p == 1) begin
        do_flush();
        for (int i = 0; i < 8; i++) push(16'(21 + i));
      end
      period = 16'(p);
      enable = 1'b1;
      for (int k = 1; k <= 12; k++) begin
        cyc();
        check("t4_refresh", a_refresh, (k >= 3) && (k <= 10));
        check("t4_underrun", a_underrun, k >= 11);
      end
      enable = 1'b0;
      cyc();
      check("t4_sb_empty", sb_q.size(), 0);
    end

    // Flush with a same-cycle push at level 5
    do_flush();
    period = 16'd100;
    for (int i = 0; i < 5; i++) push(16'(31 + i));
    check("t5_level", a_level, 5);
    enable = 1'b1;
    repeat (3) cyc();
    period  = 16'd1;
    flush   = 1'b1;
    s_valid = 1'b1;
    s_data  = 16'sd99;
    cyc();
    check("t5_flush_level", a_level, 0);
    check("t5_flush_refresh", a_refresh, 0);
    check("t5_flush_underrun", a_underrun, 0);
    flush   = 1'b0;
    s_valid = 1'b0;
    sb_q.delete();
    for (int k = 0; k < 4; k++) begin
      cyc();
      check("t5_idle_underrun", a_underrun, 0);
      check("t5_idle_level", a_level, 0);
    end

    // Asynchronous reset mid-RUN
    do_flush();
    period = 16'd2;
    for (int i = 0; i < 5; i++) push(16'(41 + i));
    enable = 1'b1;
    wait_ref(10, n);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_level", a_level, 0);
    check("t5_rst_dout", a_dout, 0);
    check("t5_rst_refresh", a_refresh, 0);
    check("t5_rst_underrun", a_underrun, 0);
    check("t5_rst_ready", a_s_ready, 1);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cyc();
      check("t5_post_rst_refresh", a_refresh, 0);
      check("t5_post_rst_underrun", a_underrun, 0);
    end
    enable = 1'b0;

    // Period shortened 10 -> 2 while cnt = 6
    do_flush();
    period = 16'd10;
    for (int i = 0; i < 8; i++) push(16'(51 + i));
    enable = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      cyc();
      check("t6_refresh", a_refresh, (k == 9) || (k == 11) || (k == 13));
      check("t6_underrun", a_underrun, 0);
      if (k == 8) period = 16'd2;
    end
    enable = 1'b0;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
